// File: rtl/perf_stats_dump_sequencer_pkg.sv
// perf_dump_pkg: shared types and constants for the statistics dump sequencer.
package perf_dump_pkg;

   // Sequencer FSM states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_PRESENT,
      ST_DONE
   } dump_state_e;

   // Bit of the controller comm word that enables counting
   localparam int COMM_COUNT_EN_BIT = 24;

   // Record select encodings understood by the controller
   localparam logic [1:0] SEL_STATS   = 2'd0;
   localparam logic [1:0] SEL_SAMPLER = 2'd1;
   localparam logic [1:0] SEL_TRACKER = 2'd2;
   localparam logic [1:0] SEL_EVICT   = 2'd3;

   // Largest number of words a single dump can return
   localparam int MAX_WORDS = 64;

endpackage

// File: rtl/perf_stats_dump_sequencer_if.sv
// Valid/ready word stream from the dump sequencer toward the host/UART bridge.
interface perf_stats_dump_sequencer_if;

   logic [31:0] data_o;
   logic        data_valid_o;
   logic        data_ready_i;

   // Sequencer side: produces words
   modport master (
      output data_o,
      output data_valid_o,
      input  data_ready_i
   );

   // Bridge side: consumes words
   modport slave (
      input  data_o,
      input  data_valid_o,
      output data_ready_i
   );

endinterface

// File: rtl/perf_stats_dump_sequencer.sv
// perf_stats_dump_sequencer: walks a window of statistics indices over the
// controller comm path and streams each returned word to the host.
// Optional feature macro: PERF_DUMP_FREEZE_EN (holds the controller count
// enable low for the whole dump so the snapshot is consistent).
module perf_stats_dump_sequencer
   import perf_dump_pkg::*;
#(
   parameter int READ_LATENCY = 1,
   parameter int IDX_BW       = 6
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              run_i,
   input  logic [1:0]        select_i,
   input  logic [IDX_BW-1:0] base_i,
   input  logic [IDX_BW:0]   count_i,
   output logic [31:0]       comm_o,
   output logic [1:0]        select_o,
   input  logic [31:0]       comm_i,
   perf_stats_dump_sequencer_if.master stream,
   output logic              busy_o,
   output logic              done_o
);

   localparam logic [2:0]      LAT_LAST  = 3'(READ_LATENCY - 1);
   localparam logic [IDX_BW:0] LAST_WORD = (IDX_BW + 1)'(1);

   dump_state_e       r_state;
   dump_state_e       w_state_nxt;
   logic [IDX_BW-1:0] r_idx;
   logic [IDX_BW:0]   r_remaining;
   logic [2:0]        r_lat;
   logic [1:0]        r_sel;
   logic [31:0]       r_data;

   logic w_accept;
   logic w_capture;
   logic w_xfer;
   logic w_leave;
   logic w_count_en;

   // State register
   always_ff @(posedge clock_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of block ordering.
      if (reset_i) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state decode, datapath strobes and status outputs
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      w_state_nxt         = r_state;
      w_accept            = 1'b0;
      w_capture           = 1'b0;
      w_xfer              = 1'b0;
      busy_o              = (r_state != ST_IDLE);
      done_o              = (r_state == ST_DONE);
      stream.data_valid_o = (r_state == ST_PRESENT);

      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_accept    = 1'b1;
               w_state_nxt = (count_i == '0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (r_lat == LAT_LAST) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (stream.data_ready_i) begin
               w_xfer      = 1'b1;
               w_state_nxt = (r_remaining == LAST_WORD) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase

      // Abort wins over everything once a dump is running
      if (abort_i && (r_state != ST_IDLE)) begin
         w_state_nxt = ST_IDLE;
         w_capture   = 1'b0;
         w_xfer      = 1'b0;
      end
   end

   // Any transition back to IDLE (completion or abort) parks the index at 0
   assign w_leave = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

   // Datapath: window pointer, remaining count, latency counter, capture
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_idx       <= '0;
         r_remaining <= '0;
         r_lat       <= '0;
         r_sel       <= SEL_STATS;
         r_data      <= '0;
      end else begin
         if (w_accept) begin
            r_sel       <= select_i;
            r_remaining <= count_i;
            // The index is what comm_o shows, so it only moves on ISSUE entry
            if (count_i != '0) r_idx <= base_i;
         end

         if (r_state == ST_ISSUE)     r_lat <= '0;
         else if (r_state == ST_WAIT) r_lat <= r_lat + 3'd1;

         if (w_capture) r_data <= comm_i;

         if (w_xfer) begin
            r_remaining <= r_remaining - LAST_WORD;
            // Natural wrap of the IDX_BW-bit index covers 63 -> 0
            if (r_remaining != LAST_WORD) r_idx <= r_idx + 1'b1;
         end

         if (w_leave) r_idx <= '0;
      end
   end

   // Count enable forwarded to the controller
`ifdef PERF_DUMP_FREEZE_EN
   assign w_count_en = run_i & (r_state == ST_IDLE);
`else
   assign w_count_en = run_i;
`endif

   // comm word: index field plus count enable, all other bits zero
   always_comb begin
      comm_o                    = '0;
      comm_o[IDX_BW-1:0]        = r_idx;
      comm_o[COMM_COUNT_EN_BIT] = w_count_en;
   end

   assign select_o    = busy_o ? r_sel : select_i;
   assign stream.data_o = r_data;

endmodule
